cache_refill_ctrl: RTL and testbench

//  Miss-side client of the pseudo-LRU replacement unit. Takes a cache miss, reads the victim way from lru_rp,

---
 rtl/cache_pkg.sv | 36 +++
 rtl/refill_beat_ctr.sv | 24 ++
 rtl/cache_refill_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and width helpers for the cache refill controller.
//   refill_state_e : refill FSM states (write-back states exist only with WRITEBACK_EN)
//   way_w/offset_w/tag_w : derived field widths
//   line_addr      : packs {tag, index, zero offset} into a line-aligned byte address
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VICTIM,
`ifdef WRITEBACK_EN
        WB_REQ,
        WB_DATA,
`endif
        FILL_REQ,
        FILL_DATA,
        INSTALL
    } refill_state_e;

    function automatic int way_w(input int assoc);
        return $clog2(assoc);
    endfunction

    function automatic int offset_w(input int words);
        return $clog2(words * 4);
    endfunction

    function automatic int tag_w(input int aw, input int iw, input int words);
        return aw - iw - offset_w(words);
    endfunction

    function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] index,
                                              input int iw, input int ow);
        return (tag << (iw + ow)) | (index << ow);
    endfunction

endpackage

// File: rtl/refill_beat_ctr.sv
// refill_beat_ctr: word-offset counter for line transfer beats.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0
//   inc      : advance one beat (wraps naturally after the last word)
//   cnt      : current word offset
//   last     : cnt is the final word of the line
module refill_beat_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = &cnt;

    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss-side refill controller feeding the pseudo-LRU replacement unit.
// Build option: WRITEBACK_EN adds dirty-victim writeback; without it the cache is write-through.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   miss_valid/ready/index/tag    miss request handshake and address fields
//   hit_valid/ready, hit_way      hit LRU update handshake
//   lru_rp                        victim way from the replacement unit
//   lru_en, select_way            one-cycle LRU update pulse and the way touched
//   vic_valid/dirty/tag           metadata of the victim way at meta_index
//   meta_index                    latched set index driving the arrays
//   mem_req_valid/ready/write/addr  memory request channel
//   mem_beat_valid                one data beat transferred
//   beat_word, data_we            data array word offset and refill write enable
//   tag_we, refill_done           tag install strobe and completion pulse
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter  int ASSOCIATIVITY = 4,
    parameter  int INDEX_WIDTH   = 5,
    parameter  int ADDR_WIDTH    = 32,
    parameter  int LINE_WORDS    = 4,
    localparam int WAY_W         = way_w(ASSOCIATIVITY),
    localparam int OFFSET_W      = offset_w(LINE_WORDS),
    localparam int TAG_W         = tag_w(ADDR_WIDTH, INDEX_WIDTH, LINE_WORDS),
    localparam int BEAT_W        = $clog2(LINE_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_valid,
    output logic                   miss_ready,
    input  logic [INDEX_WIDTH-1:0] miss_index,
    input  logic [TAG_W-1:0]       miss_tag,
    input  logic                   hit_valid,
    output logic                   hit_ready,
    input  logic [WAY_W-1:0]       hit_way,
    input  logic [WAY_W-1:0]       lru_rp,
    output logic                   lru_en,
    output logic [WAY_W-1:0]       select_way,
    input  logic                   vic_valid,
    input  logic                   vic_dirty,
    input  logic [TAG_W-1:0]       vic_tag,
    output logic [INDEX_WIDTH-1:0] meta_index,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_write,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_beat_valid,
    output logic [BEAT_W-1:0]      beat_word,
    output logic                   data_we,
    output logic                   tag_we,
    output logic                   refill_done
);

    refill_state_e    state;
    logic [TAG_W-1:0] tag_q;
    logic [WAY_W-1:0] way_q;
    logic             hit_rdy_q;
    logic             in_data;
    logic             beat_inc;
    logic             beat_last;
    logic [ADDR_WIDTH-1:0] fill_addr;

    // A pending miss always wins over a same-cycle hit.
    assign hit_ready = hit_rdy_q & ~miss_valid;
    assign data_we   = (state == FILL_DATA) & mem_beat_valid;
    assign beat_inc  = in_data & mem_beat_valid;
    assign fill_addr = ADDR_WIDTH'(line_addr(64'(tag_q), 64'(meta_index), INDEX_WIDTH, OFFSET_W));

`ifdef WRITEBACK_EN
    logic wr_q;
    assign mem_req_write = wr_q;
    assign in_data       = (state == FILL_DATA) || (state == WB_DATA);
`else
    logic unused_wt;
    assign unused_wt     = ^{vic_valid, vic_dirty, vic_tag};
    assign mem_req_write = 1'b0;
    assign in_data       = state == FILL_DATA;
`endif

    refill_beat_ctr #(.W(BEAT_W)) u_beat (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .inc  (beat_inc),
        .cnt  (beat_word),
        .last (beat_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            miss_ready    <= 1'b1;
            hit_rdy_q     <= 1'b1;
            lru_en        <= 1'b0;
            select_way    <= '0;
            meta_index    <= '0;
            tag_q         <= '0;
            way_q         <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            tag_we        <= 1'b0;
            refill_done   <= 1'b0;
`ifdef WRITEBACK_EN
            wr_q          <= 1'b0;
`endif
        end else begin
            lru_en      <= 1'b0;
            tag_we      <= 1'b0;
            refill_done <= 1'b0;
            case (state)
                IDLE:
                    if (miss_valid && miss_ready) begin
                        state      <= VICTIM;
                        miss_ready <= 1'b0;
                        hit_rdy_q  <= 1'b0;
                        meta_index <= miss_index;
                        tag_q      <= miss_tag;
                    end else if (hit_valid && hit_ready) begin
                        // Drop hit_ready while lru_en is high so pulses never abut.
                        lru_en     <= 1'b1;
                        select_way <= hit_way;
                        hit_rdy_q  <= 1'b0;
                    end else begin
                        hit_rdy_q  <= 1'b1;
                    end
                VICTIM: begin
                    way_q         <= lru_rp;
                    mem_req_valid <= 1'b1;
`ifdef WRITEBACK_EN
                    if (vic_valid && vic_dirty) begin
                        state        <= WB_REQ;
                        wr_q         <= 1'b1;
                        mem_req_addr <= ADDR_WIDTH'(line_addr(64'(vic_tag), 64'(meta_index),
                                                              INDEX_WIDTH, OFFSET_W));
                    end else
`endif
                    begin
                        state        <= FILL_REQ;
                        mem_req_addr <= fill_addr;
                    end
                end
`ifdef WRITEBACK_EN
                WB_REQ:
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WB_DATA;
                    end
                WB_DATA:
                    if (beat_inc && beat_last) begin
                        state         <= FILL_REQ;
                        mem_req_valid <= 1'b1;
                        wr_q          <= 1'b0;
                        mem_req_addr  <= fill_addr;
                    end
`endif
                FILL_REQ:
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= FILL_DATA;
                    end
                FILL_DATA:
                    if (beat_inc && beat_last) begin
                        state       <= INSTALL;
                        tag_we      <= 1'b1;
                        lru_en      <= 1'b1;
                        select_way  <= way_q;
                        refill_done <= 1'b1;
                    end
                INSTALL: begin
                    state      <= IDLE;
                    miss_ready <= 1'b1;
                    hit_rdy_q  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed + randomized self-checking bench for cache_refill_ctrl.
module tb_cache_refill_ctrl;

    localparam int IW = 5;
    localparam int AW = 32;
    localparam int LW = 4;
    localparam int OW = 4;
    localparam int TW = AW - IW - OW;
    localparam int WW = 2;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          miss_valid = 1'b0, miss_ready;
    logic [IW-1:0] miss_index = '0;
    logic [TW-1:0] miss_tag = '0;
    logic          hit_valid = 1'b0, hit_ready;
    logic [WW-1:0] hit_way = '0;
    logic [WW-1:0] lru_rp = '0;
    logic          lru_en;
    logic [WW-1:0] select_way;
    logic          vic_valid = 1'b0, vic_dirty = 1'b0;
    logic [TW-1:0] vic_tag = '0;
    logic [IW-1:0] meta_index;
    logic          mem_req_valid, mem_req_ready = 1'b0, mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic          mem_beat_valid = 1'b0;
    logic [BW-1:0] beat_word;
    logic          data_we, tag_we, refill_done;

    int checks = 0;
    int errors = 0;
    int n_upd;
    logic prev_en;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_index(miss_index), .miss_tag(miss_tag),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_way(hit_way),
        .lru_rp(lru_rp), .lru_en(lru_en), .select_way(select_way),
        .vic_valid(vic_valid), .vic_dirty(vic_dirty), .vic_tag(vic_tag), .meta_index(meta_index),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_beat_valid(mem_beat_valid), .beat_word(beat_word),
        .data_we(data_we), .tag_we(tag_we), .refill_done(refill_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line address model: tag above index above byte offset, offset zero.
    function automatic logic [AW-1:0] exp_addr(input logic [TW-1:0] tag, input logic [IW-1:0] idx);
        return AW'(tag * (64'd1 << (IW + OW)) + idx * (64'd1 << OW));
    endfunction

    task automatic chk_reset_outs(input string p);
        chk({p, "_miss_ready"}, miss_ready, 1);
        chk({p, "_hit_ready"}, hit_ready, 1);
        chk({p, "_lru_en"}, lru_en, 0);
        chk({p, "_select_way"}, select_way, 0);
        chk({p, "_meta_index"}, meta_index, 0);
        chk({p, "_req_valid"}, mem_req_valid, 0);
        chk({p, "_req_write"}, mem_req_write, 0);
        chk({p, "_req_addr"}, mem_req_addr, 0);
        chk({p, "_beat_word"}, beat_word, 0);
        chk({p, "_data_we"}, data_we, 0);
        chk({p, "_tag_we"}, tag_we, 0);
        chk({p, "_refill_done"}, refill_done, 0);
    endtask

    // Memory side: hold off acceptance d cycles (with stray beats), then LW beats with random gaps.
    task automatic serve(input bit wr, input logic [AW-1:0] a, input int d, input bit fill,
                         input int abort_beat, output bit aborted);
        for (int c = 0; c <= d; c++) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_write", mem_req_write, wr);
            chk("req_addr", mem_req_addr, a);
            mem_beat_valid = 1'($urandom_range(0, 1));
            mem_req_ready  = (c == d);
            #1 chk("we_in_req", data_we, 0);
            @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_beat_valid = 1'b0;
        chk("req_dropped", mem_req_valid, 0);
        for (int k = 0; k < LW; k++) begin
            repeat ($urandom_range(0, 2)) begin
                #1 chk("gap_we", data_we, 0);
                chk("gap_beat_word", beat_word, k);
                @(negedge clk);
            end
            mem_beat_valid = 1'b1;
            if (k == abort_beat) rst = 1'b1;
            #1 chk("beat_word", beat_word, k);
            chk("beat_we", data_we, fill);
            @(negedge clk);
            mem_beat_valid = 1'b0;
            if (rst) begin
                aborted = 1'b1;
                return;
            end
        end
        aborted = 1'b0;
    endtask

    task automatic run_miss(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic [WW-1:0] way,
                            input bit dirty, input logic [TW-1:0] vtag, input int d,
                            input bit with_hit, input logic [WW-1:0] hw, input int abort_beat);
        bit ab;
        bit wb;
        chk("idle_miss_ready", miss_ready, 1);
        miss_valid = 1'b1;
        miss_index = idx;
        miss_tag   = tag;
        hit_valid  = with_hit;
        hit_way    = hw;
        if (with_hit) #1 chk("hit_ready_vs_miss", hit_ready, 0);
        @(negedge clk);
        miss_valid = 1'b0;
        miss_index = IW'($urandom);
        miss_tag   = TW'($urandom);
        chk("victim_meta_index", meta_index, idx);
        chk("victim_miss_ready", miss_ready, 0);
        chk("victim_lru_en", lru_en, 0);
        if (with_hit) chk("busy_hit_ready", hit_ready, 0);
        lru_rp    = way;
        vic_valid = 1'b1;
        vic_dirty = dirty;
        vic_tag   = vtag;
        @(negedge clk);
        lru_rp    = ~way;
        vic_dirty = 1'($urandom);
        vic_tag   = TW'($urandom);
`ifdef WRITEBACK_EN
        wb = dirty;
`else
        wb = 1'b0;
`endif
        if (wb) serve(1'b1, exp_addr(vtag, idx), $urandom_range(0, 3), 1'b0, -1, ab);
        serve(1'b0, exp_addr(tag, idx), d, 1'b1, abort_beat, ab);
        if (ab) begin
            rst = 1'b0;
            chk_reset_outs("abort");
            return;
        end
        chk("install_tag_we", tag_we, 1);
        chk("install_lru_en", lru_en, 1);
        chk("install_select_way", select_way, way);
        chk("install_refill_done", refill_done, 1);
        chk("install_meta_index", meta_index, idx);
        chk("install_req_valid", mem_req_valid, 0);
        if (with_hit) chk("install_hit_ready", hit_ready, 0);
        @(negedge clk);
        chk("post_refill_done", refill_done, 0);
        chk("post_lru_en", lru_en, 0);
        chk("post_tag_we", tag_we, 0);
        chk("post_miss_ready", miss_ready, 1);
        if (with_hit) begin
            chk("post_hit_ready", hit_ready, 1);
            @(negedge clk);
            hit_valid = 1'b0;
            chk("deferred_hit_lru_en", lru_en, 1);
            chk("deferred_hit_way", select_way, hw);
            chk("deferred_hit_ready", hit_ready, 0);
            @(negedge clk);
            chk("deferred_hit_once", lru_en, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("reset_idle");

        // Clean miss, fixed vector.
        run_miss(5'd3, TW'('h1A5), 2'd2, 1'b0, '0, 0, 1'b0, '0, -1);

        // Dirty victim (writeback only when built in) with way latched across lru_rp change.
        run_miss(IW'($urandom), TW'($urandom), 2'd1, 1'b1, TW'('h7), $urandom_range(0, 2), 1'b0, '0, -1);

        // Held hit: updates only on alternate cycles.
        n_upd     = 0;
        prev_en   = 1'b0;
        hit_valid = 1'b1;
        hit_way   = 2'd1;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) hit_valid = 1'b0;
            @(negedge clk);
            if (lru_en) begin
                n_upd++;
                chk("hold_hit_way", select_way, 1);
            end
            chk("lru_not_back_to_back", lru_en & prev_en, 0);
            prev_en = lru_en;
        end
        chk("hold_hit_updates", n_upd, 2);

        // Same-cycle miss and hit.
        run_miss(IW'($urandom), TW'($urandom), 2'd0, 1'b0, '0, 1, 1'b1, 2'd3, -1);

        // Slow request acceptance.
        run_miss(IW'($urandom), TW'($urandom), 2'd3, 1'b1, TW'($urandom), 5, 1'b0, '0, -1);

        // Reset during the third fill beat, then a clean recovery miss.
        run_miss(IW'($urandom), TW'($urandom), 2'd1, 1'b0, '0, 0, 1'b0, '0, 2);
        run_miss(IW'($urandom), TW'($urandom), 2'd2, 1'b0, '0, 1, 1'b0, '0, -1);

        // Randomized misses.
        for (int i = 0; i < 8; i++)
            run_miss(IW'($urandom), TW'($urandom), WW'($urandom), 1'($urandom), TW'($urandom),
                     $urandom_range(0, 3), 1'($urandom), WW'($urandom), -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
